// File: rtl/result_fifo_pkg.sv
// Shared sizing for result_fifo: default geometry, pointer width derivation,
// and the drop counter width.
package result_fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DROP_CNT_W = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for result_fifo: one synchronous write port, one asynchronous read port.
// Zero read latency, no reset and no flow control; the caller owns all of that.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through ALU result queue, 1-cycle write-to-read latency, no bypass.
// A write while full with no pop is dropped and sets sticky overflow; RESULT_FIFO_DROPCNT_EN adds drop_cnt.
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ptr_w(DEPTH):0]       count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow
`ifdef RESULT_FIFO_DROPCNT_EN
  ,
  output logic [DROP_CNT_W-1:0]       drop_cnt
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

  always_comb begin
    pop        = out_valid && out_ready;
    // A pop frees the slot in the same edge, so a full FIFO can still accept.
    push       = in_valid && (!full || pop);
    drop       = in_valid && full && !pop;
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RESULT_FIFO_DROPCNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (in_data),
    .raddr (head_q),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo at DEPTH=8, WIDTH=8; inputs change 1ns after
// each rising edge and outputs are sampled there too.
module tb_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
`ifdef RESULT_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
`ifdef RESULT_FIFO_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset values are visible before any clock edge.
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset.
    step();
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_count", 32'(count), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_overflow", 32'(overflow), 32'd0);

    // Three pushes, consumer stalled; first word falls through after one edge.
    in_valid = 1'b1; in_data = 8'h11;
    step();
    check("p1_count", 32'(count), 32'd1);
    check("p1_out_valid", 32'(out_valid), 32'd1);
    check("p1_out_data", 32'(out_data), 32'h11);
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    in_valid = 1'b0;
    check("p3_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    check("d0_data", 32'(out_data), 32'h11);
    step();
    check("d1_count", 32'(count), 32'd2);
    check("d1_data", 32'(out_data), 32'h22);
    step();
    check("d2_count", 32'(count), 32'd1);
    check("d2_data", 32'(out_data), 32'h33);
    step();
    check("d3_count", 32'(count), 32'd0);
    check("d3_empty", 32'(empty), 32'd1);
    // Pop request on empty is ignored.
    step();
    check("underflow_count", 32'(count), 32'd0);
    check("underflow_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Fill to DEPTH, then one more write is dropped.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'hA0 + 8'(i);
      step();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_overflow", 32'(overflow), 32'd0);
    in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(out_data), 32'hA0);
`ifdef RESULT_FIFO_DROPCNT_EN
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    step();
    check("ovf_sticky", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_data), 32'hA0 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);

    // Streaming push+pop across pointer wrap keeps one entry resident.
    in_valid = 1'b1; in_data = 8'h3F;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h40 + 8'(i);
      check($sformatf("stream_data_%0d", i), 32'(out_data), (i == 0) ? 32'h3F : 32'h40 + 32'(i - 1));
      step();
      check($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    check("stream_last", 32'(out_data), 32'h53);
    step();
    out_ready = 1'b0;
    check("stream_empty", 32'(empty), 32'd1);

    // Mid-operation asynchronous reset discards contents.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'hB0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("load5_count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_overflow", 32'(overflow), 32'd0);
`ifdef RESULT_FIFO_DROPCNT_EN
    check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h07;
    step();
    in_valid = 1'b0;
    check("post_rst_data", 32'(out_data), 32'h07);
    check("post_rst_count", 32'(count), 32'd1);

    // Full FIFO with simultaneous push and pop: accepted, count holds, no overflow.
    in_valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      in_data = 8'hC0 + 8'(i);
      step();
    end
    check("full2_full", 32'(full), 32'd1);
    in_data = 8'h5A; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_count", 32'(count), 32'd8);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_head", 32'(out_data), 32'hC1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(out_data), (i == 7) ? 32'h5A : 32'hC1 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("pp_final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data width, matching the 8-bit ALU result bus.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: ALU result from the upstream datapath.
REQ-006 The block SHALL have port in_valid, input, 1 bit: write request for in_data this cycle.
REQ-007 The block SHALL have port out_data, output, WIDTH bits: oldest stored entry (head).
REQ-008 The block SHALL have port out_valid, output, 1 bit: head holds valid data.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts head this cycle.
REQ-010 The block SHALL have port count, output, log2(DEPTH)+1 bits: number of stored entries.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: count==DEPTH and count==0 respectively.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, a write was dropped.

Function
REQ-013 Pop SHALL occur on a rising edge when out_valid && out_ready; head pointer advances by one.
REQ-014 Push SHALL occur on a rising edge when in_valid && (!full || pop); in_data is stored at the tail and the tail advances by one.
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL be incremented on push-only, decremented on pop-only, unchanged on push+pop.
REQ-016 out_data SHALL be first-word-fall-through: combinationally the entry at head; out_valid SHALL equal !empty.
REQ-017 Latency SHALL be one cycle: data pushed at edge N is visible on out_data with out_valid high after edge N; no same-cycle bypass when empty.
REQ-018 When full, in_valid high and pop also occurring, the push SHALL be accepted and count SHALL stay DEPTH.
REQ-019 When full, in_valid high and no pop, in_data SHALL be discarded, storage unchanged, overflow set at that edge.
REQ-020 When empty, out_ready SHALL have no effect; count SHALL never underflow.
REQ-021 out_data SHALL be unspecified while out_valid is low; the consumer SHALL ignore it.

Reset
REQ-022 While rst_n is low, head, tail and count SHALL be 0; empty=1, full=0, out_valid=0, overflow=0, immediately and independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard all stored entries; storage array contents need not be reset.
REQ-024 The first push SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 With macro RESULT_FIFO_DROPCNT_EN defined, an extra output drop_cnt (8 bits) SHALL count discarded writes per REQ-019, saturating at 255, reset to 0.
REQ-026 Without RESULT_FIFO_DROPCNT_EN, port drop_cnt and its counter SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package result_fifo_pkg SHALL hold the WIDTH and DEPTH default constants, the pointer-width constant derivation and the drop-counter width.
REQ-028 Storage SHALL be a sub-module fifo_mem (write port: clk, we, waddr, wdata; asynchronous read port: raddr, rdata; no reset); control and flags SHALL stay in result_fifo.

Verification
REQ-029 Reset then idle -> empty=1, full=0, count=0, out_valid=0, overflow=0.
REQ-030 Push 0x11,0x22,0x33 with out_ready=0, then out_ready=1 for 3 cycles -> out_data 0x11,0x22,0x33 in order; count 3,2,1,0; empty=1 after.
REQ-031 Push 8 values 0xA0..0xA7 then push 0xFF with out_ready=0 -> full=1, count=8, 0xFF dropped, overflow=1, drop_cnt=1 when enabled; drain yields 0xA0..0xA7.
REQ-032 Full FIFO, in_valid=1 with 0x5A and out_ready=1 same cycle -> head popped, 0x5A accepted at tail, count stays 8, overflow stays 0.
REQ-033 Push/pop continuously for 20 cycles at DEPTH=8 (pointer wrap) -> output sequence equals input sequence, count constant at 1.
REQ-034 Load 5 entries, assert rst_n low between clock edges -> count=0, out_valid=0 immediately; after release, push 0x07 -> out_data=0x07 next cycle.
